// File: rtl/mux2_arbiter_pkg.sv
// Shared types and helpers for the two-requester mux2 arbiter.
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETTLE = 2'd1,
        ARB_GRANT0 = 2'd2,
        ARB_GRANT1 = 2'd3
    } arb_state_t;

    localparam logic SEL_D0 = 1'b0;
    localparam logic SEL_D1 = 1'b1;

    localparam int unsigned SETTLE_W = 4;

    // Round-robin pick: a lone requester wins, a tie goes to the side that was not served last.
    function automatic logic rr_winner(input logic req0, input logic req1, input logic last);
        return (req0 && req1) ? ~last : req1;
    endfunction

    function automatic arb_state_t grant_state(input logic side);
        return side ? ARB_GRANT1 : ARB_GRANT0;
    endfunction

endpackage

// File: rtl/arb_hold_cnt.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
module arb_hold_cnt #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned SAT_VAL = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic term_c_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear wins over enable; counting stops at SAT_VAL.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != WIDTH'(SAT_VAL))) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_c_o = (cnt_q == WIDTH'(SAT_VAL));

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter owning the select of a shared 2->1 mux, with settle gaps and hold-limit preemption.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic busy,
    output logic preempt
);

    localparam int unsigned HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int unsigned HOLD_SAT = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic                sel_q;
    logic                sel_d;
    logic                last_q;
    logic                last_d;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] settle_d;
    logic                gnt0_q;
    logic                gnt1_q;
    logic                busy_q;
    logic                preempt_q;
    logic                preempt_d;

    logic hold_clr;
    logic hold_en;
    logic hold_term_c;
    logic granted_q;
    logic granted_d;
    logic owner;
    logic req_own;
    logic req_oth;
    logic req_tgt;
    logic req_alt;
    logic win;

    arb_hold_cnt #(
        .WIDTH   (HOLD_W),
        .SAT_VAL (HOLD_SAT)
    ) u_hold_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (hold_clr),
        .en_i     (hold_en),
        .term_c_o (hold_term_c)
    );

    // Next-state decode; sel only moves on transitions into SETTLE.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        settle_d  = settle_q;
        preempt_d = 1'b0;

        win     = rr_winner(req0, req1, last_q);
        owner   = (state_q == ARB_GRANT1);
        req_own = owner ? req1 : req0;
        req_oth = owner ? req0 : req1;
        req_tgt = sel_q ? req1 : req0;
        req_alt = sel_q ? req0 : req1;

        case (state_q)
            ARB_IDLE: begin
                if (req0 || req1) begin
                    if (win == sel_q) begin
                        state_d = grant_state(win);
                        last_d  = win;
                    end else begin
                        sel_d    = win;
                        settle_d = '0;
                        state_d  = ARB_SETTLE;
                    end
                end
            end
            ARB_SETTLE: begin
                if (!req_tgt) begin
                    if (req_alt) begin
                        sel_d    = ~sel_q;
                        settle_d = '0;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) begin
                    state_d = grant_state(sel_q);
                    last_d  = sel_q;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ARB_GRANT0, ARB_GRANT1: begin
                if (!req_own) begin
                    if (req_oth) begin
                        sel_d    = ~owner;
                        settle_d = '0;
                        state_d  = ARB_SETTLE;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if ((MAX_HOLD != 0) && hold_term_c && req_oth) begin
                    preempt_d = 1'b1;
                    sel_d     = ~owner;
                    settle_d  = '0;
                    state_d   = ARB_SETTLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        granted_q = (state_q == ARB_GRANT0) || (state_q == ARB_GRANT1);
        granted_d = (state_d == ARB_GRANT0) || (state_d == ARB_GRANT1);
        hold_clr  = granted_d && !granted_q;
        hold_en   = granted_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            sel_q    <= SEL_D0;
            last_q   <= SEL_D1;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            settle_q <= settle_d;
        end
    end

    // Outputs registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            gnt0_q    <= (state_d == ARB_GRANT0);
            gnt1_q    <= (state_d == ARB_GRANT1);
            busy_q    <= (state_d != ARB_IDLE);
            preempt_q <= preempt_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed and randomised checks for mux2_arbiter with a bench-side gate-level mux on sel.
module tb_mux2_arbiter;

    localparam int unsigned SETTLE_CYC = 2;
    localparam int unsigned MAX_HOLD   = 8;
    localparam int          LIM        = MAX_HOLD + 2 * SETTLE_CYC + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic req0  = 1'b0;
    logic req1  = 1'b0;
    logic gnt0, gnt1, sel, busy, preempt;
    logic nh_gnt0, nh_gnt1, nh_sel, nh_busy, nh_preempt;
    logic [7:0] d0, d1, z;
    logic [4:0] st;

    int n_cmp = 0;
    int n_err = 0;

    mux2_arbiter #(.SETTLE_CYC(SETTLE_CYC), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .busy(busy), .preempt(preempt)
    );

    mux2_arbiter #(.SETTLE_CYC(SETTLE_CYC), .MAX_HOLD(0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .gnt0(nh_gnt0), .gnt1(nh_gnt1), .sel(nh_sel), .busy(nh_busy), .preempt(nh_preempt)
    );

    // NAND-style 2:1 mux on the arbiter's select.
    assign z  = ~(~(d0 & {8{~sel}}) & ~(d1 & {8{sel}}));
    assign st = {gnt0, gnt1, sel, busy, preempt};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        tick();
        n_cmp++;
        if (st !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_state: {gnt0,gnt1,sel,busy,preempt}=%b want 00000", st);
        end
        do_reset();
    endtask

    task automatic test_fast_path();
        do_reset();
        req0 = 1'b1;
        tick();
        n_cmp++;
        if (st !== 5'b10010) begin
            n_err++;
            $display("FAIL fast_grant: st=%b want 10010", st);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (st !== 5'b10010) begin
            n_err++;
            $display("FAIL fast_hold: st=%b want 10010", st);
        end
        req0 = 1'b0;
        tick();
        n_cmp++;
        if (st !== 5'b00000) begin
            n_err++;
            $display("FAIL fast_release: st=%b want 00000", st);
        end
    endtask

    task automatic test_switch();
        do_reset();
        req1 = 1'b1;
        tick();
        n_cmp++;
        if (st !== 5'b00110) begin
            n_err++;
            $display("FAIL switch_settle1: st=%b want 00110", st);
        end
        n_cmp++;
        if (z !== d1) begin
            n_err++;
            $display("FAIL switch_mux_z: z=%h want %h", z, d1);
        end
        tick();
        n_cmp++;
        if (st !== 5'b00110) begin
            n_err++;
            $display("FAIL switch_settle2: st=%b want 00110", st);
        end
        tick();
        n_cmp++;
        if (st !== 5'b01110) begin
            n_err++;
            $display("FAIL switch_grant1: st=%b want 01110", st);
        end
        req1 = 1'b0;
        tick();
        n_cmp++;
        if (st !== 5'b00100) begin
            n_err++;
            $display("FAIL switch_idle_sel_holds: st=%b want 00100", st);
        end
    endtask

    task automatic test_tie_rr();
        logic [4:0] exp_seq [6];
        exp_seq = '{5'b00110, 5'b00110, 5'b01110, 5'b00010, 5'b00010, 5'b10010};
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        n_cmp++;
        if (st !== 5'b10010) begin
            n_err++;
            $display("FAIL tie_first_gnt0: st=%b want 10010", st);
        end
        req0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (st !== exp_seq[i]) begin
                n_err++;
                $display("FAIL tie_rr_step%0d: st=%b want %b", i, st, exp_seq[i]);
            end
            if (i == 2) begin
                req0 = 1'b1;
                req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_preempt();
        int cnt    = 0;
        int pulses = 0;
        int nh_drop = 0;
        do_reset();
        req0 = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (gnt0) cnt++;
            if (preempt) pulses++;
            if (!nh_gnt0) nh_drop++;
            if (i == 2) req1 = 1'b1;
            if (!gnt0) break;
            tick();
        end
        n_cmp++;
        if (cnt != 8) begin
            n_err++;
            $display("FAIL preempt_hold_len: gnt0 cycles=%0d want 8", cnt);
        end
        n_cmp++;
        if (st !== 5'b00111 || pulses != 1) begin
            n_err++;
            $display("FAIL preempt_pulse: st=%b pulses=%0d want 00111 and 1", st, pulses);
        end
        tick();
        n_cmp++;
        if (st !== 5'b00110) begin
            n_err++;
            $display("FAIL preempt_settle: st=%b want 00110", st);
        end
        tick();
        n_cmp++;
        if (st !== 5'b01110) begin
            n_err++;
            $display("FAIL preempt_gnt1: st=%b want 01110", st);
        end
        n_cmp++;
        if (nh_drop != 0 || nh_gnt0 !== 1'b1 || nh_preempt !== 1'b0) begin
            n_err++;
            $display("FAIL nohold_keeps_gnt0: drops=%0d gnt0=%b preempt=%b want 0 1 0",
                     nh_drop, nh_gnt0, nh_preempt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req1 = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if (st !== 5'b01110) begin
            n_err++;
            $display("FAIL rstmid_reach_grant1: st=%b want 01110", st);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (st !== 5'b00000) begin
            n_err++;
            $display("FAIL rstmid_in_grant: st=%b want 00000", st);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (st !== 5'b00110) begin
            n_err++;
            $display("FAIL rstmid_reach_settle: st=%b want 00110", st);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (st !== 5'b00000) begin
            n_err++;
            $display("FAIL rstmid_in_settle: st=%b want 00000", st);
        end
        rst_n = 1'b1;
        req0  = 1'b1;
        tick();
        n_cmp++;
        if (st !== 5'b10010) begin
            n_err++;
            $display("FAIL rstmid_tie_gnt0: st=%b want 10010", st);
        end
    endtask

    task automatic test_random();
        int   w0 = 0, w1 = 0, u0 = 0, u1 = 0, l0 = 5, l1 = 5, npre = 0;
        logic psel;
        logic bad;
        do_reset();
        psel = sel;
        for (int i = 0; i < 10000; i++) begin
            tick();
            w0 = (req0 && !gnt0) ? w0 + 1 : 0;
            w1 = (req1 && !gnt1) ? w1 + 1 : 0;
            if (preempt) npre++;
            bad = (gnt0 && gnt1) || (gnt0 && sel !== 1'b0) || (gnt1 && sel !== 1'b1) ||
                  ((sel !== psel) && (gnt0 || gnt1 || !busy));
            n_cmp++;
            if (bad) begin
                n_err++;
                $display("FAIL rand_invariant: cycle=%0d st=%b prev_sel=%b", i, st, psel);
            end
            n_cmp++;
            if (w0 == LIM + 1 || w1 == LIM + 1) begin
                n_err++;
                $display("FAIL rand_starvation: cycle=%0d wait0=%0d wait1=%0d limit=%0d", i, w0, w1, LIM);
            end
            psel = sel;
            if (!req0) begin
                if ($urandom_range(3) == 0) begin
                    req0 = 1'b1;
                    l0   = int'($urandom_range(20, 1));
                    u0   = 0;
                end
            end else if (gnt0) begin
                u0++;
                if (u0 >= l0) req0 = 1'b0;
            end
            if (!req1) begin
                if ($urandom_range(3) == 0) begin
                    req1 = 1'b1;
                    l1   = int'($urandom_range(20, 1));
                    u1   = 0;
                end
            end else if (gnt1) begin
                u1++;
                if (u1 >= l1) req1 = 1'b0;
            end
        end
        n_cmp++;
        if (npre == 0) begin
            n_err++;
            $display("FAIL rand_preempt_seen: preempt pulses=%0d want >0", npre);
        end
    endtask

    initial begin
        d0 = 8'hA5;
        d1 = 8'h3C;
        test_reset();
        test_fast_path();
        test_switch();
        test_tie_rr();
        test_preempt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
